// File: rtl/dtg_pkg.sv
// ============================================================================
// Package     : dtg_pkg
// Description : Shared leg state encoding and default constants for the
//               dead-band bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dtg_pkg;

  localparam int c_DT_W_DEF   = 8;
  localparam int c_DT_RST_DEF = 15;
  localparam int c_N_LEG_DEF  = 3;

  typedef logic [1:0] leg_state_t;

  localparam leg_state_t LOW_ON  = 2'd0;
  localparam leg_state_t DEAD_H  = 2'd1;
  localparam leg_state_t HIGH_ON = 2'd2;
  localparam leg_state_t DEAD_L  = 2'd3;

endpackage : dtg_pkg

`default_nettype wire

// File: rtl/dead_band_bridge_if.sv
// ============================================================================
// Interface   : dead_band_bridge_if
// Description : PWM command / gate bundle between the modulator (master) and
//               the dead-band bridge (slave). Fault signals exist only when
//               DTG_FAULT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dead_band_bridge_if #(
  parameter int N_LEG = 3,
  parameter int DT_W  = 8
);

  logic [N_LEG-1:0] gi;
  logic [DT_W-1:0]  dt_rise;
  logic [DT_W-1:0]  dt_fall;
  logic             dt_load;
  logic [N_LEG-1:0] go_h;
  logic [N_LEG-1:0] go_l;
  logic [N_LEG-1:0] busy;

`ifdef DTG_FAULT_EN
  logic             fault;
  logic             fault_clr;
  logic             fault_q;

  modport master (
    output gi, dt_rise, dt_fall, dt_load, fault, fault_clr,
    input  go_h, go_l, busy, fault_q
  );

  modport slave (
    input  gi, dt_rise, dt_fall, dt_load, fault, fault_clr,
    output go_h, go_l, busy, fault_q
  );
`else
  modport master (
    output gi, dt_rise, dt_fall, dt_load,
    input  go_h, go_l, busy
  );

  modport slave (
    input  gi, dt_rise, dt_fall, dt_load,
    output go_h, go_l, busy
  );
`endif

endinterface : dead_band_bridge_if

`default_nettype wire

// File: rtl/dtg_leg.sv
// ============================================================================
// Module      : dtg_leg
// Description : One bridge leg: complementary gate FSM with a per-leg dead
//               counter and a limit captured on each dead-interval entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtg_leg
  import dtg_pkg::*;
#(
  parameter int DT_W   = c_DT_W_DEF,
  parameter int DT_RST = c_DT_RST_DEF
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_gi,
  input  wire logic [DT_W-1:0] i_rise,
  input  wire logic [DT_W-1:0] i_fall,
  input  wire logic            i_hold,
  output logic                 o_go_h,
  output logic                 o_go_l,
  output logic                 o_busy
);

  leg_state_t      r_state;
  logic [DT_W-1:0] r_cnt;
  logic [DT_W-1:0] r_limit;
  logic            r_go_h;
  logic            r_go_l;
  logic            r_busy;
  logic            w_done;

  // A zero limit can only reach a dead state via reset or hold release;
  // treat it as already expired so the counter never wraps.
  assign w_done = (r_limit == '0) || (r_cnt == (r_limit - DT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DEAD_L;
      r_cnt   <= '0;
      r_limit <= DT_W'(DT_RST);
      r_go_h  <= 1'b0;
      r_go_l  <= 1'b0;
      r_busy  <= 1'b1;
    end else if (i_hold) begin
      r_state <= DEAD_L;
      r_cnt   <= '0;
      r_limit <= i_fall;
      r_go_h  <= 1'b0;
      r_go_l  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        LOW_ON: begin
          if (i_gi) begin
            r_go_l <= 1'b0;
            if (i_rise == '0) begin
              r_state <= HIGH_ON;
              r_go_h  <= 1'b1;
            end else begin
              r_state <= DEAD_H;
              r_limit <= i_rise;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
        end
        DEAD_H: begin
          if (!i_gi) begin
            r_state <= LOW_ON;
            r_go_l  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_done) begin
            r_state <= HIGH_ON;
            r_go_h  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + DT_W'(1);
          end
        end
        HIGH_ON: begin
          if (!i_gi) begin
            r_go_h <= 1'b0;
            if (i_fall == '0) begin
              r_state <= LOW_ON;
              r_go_l  <= 1'b1;
            end else begin
              r_state <= DEAD_L;
              r_limit <= i_fall;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
        end
        DEAD_L: begin
          if (i_gi) begin
            r_state <= HIGH_ON;
            r_go_h  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_done) begin
            r_state <= LOW_ON;
            r_go_l  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + DT_W'(1);
          end
        end
        default: begin
          r_state <= DEAD_L;
          r_cnt   <= '0;
          r_go_h  <= 1'b0;
          r_go_l  <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign o_go_h = r_go_h;
  assign o_go_l = r_go_l;
  assign o_busy = r_busy;

endmodule : dtg_leg

`default_nettype wire

// File: rtl/dead_band_bridge.sv
// ============================================================================
// Module      : dead_band_bridge
// Description : Multi-leg complementary dead-time generator. Holds the shared
//               dead-time shadow registers and, with DTG_FAULT_EN defined, a
//               sticky fault latch that forces every leg off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dead_band_bridge
  import dtg_pkg::*;
#(
  parameter int N_LEG  = c_N_LEG_DEF,
  parameter int DT_W   = c_DT_W_DEF,
  parameter int DT_RST = c_DT_RST_DEF
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dead_band_bridge_if.slave bus
);

  logic [DT_W-1:0]  r_rise;
  logic [DT_W-1:0]  r_fall;
  logic             w_hold;
  logic [N_LEG-1:0] w_go_h;
  logic [N_LEG-1:0] w_go_l;
  logic [N_LEG-1:0] w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= DT_W'(DT_RST);
      r_fall <= DT_W'(DT_RST);
    end else if (bus.dt_load) begin
      r_rise <= bus.dt_rise;
      r_fall <= bus.dt_fall;
    end
  end

`ifdef DTG_FAULT_EN
  logic r_fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_q <= 1'b0;
    end else if (bus.fault) begin
      r_fault_q <= 1'b1;
    end else if (bus.fault_clr) begin
      r_fault_q <= 1'b0;
    end
  end

  // Raw fault is included so gates drop on the same edge the latch sets.
  assign w_hold      = bus.fault | r_fault_q;
  assign bus.fault_q = r_fault_q;
`else
  assign w_hold = 1'b0;
`endif

  generate
    for (genvar gi_idx = 0; gi_idx < N_LEG; gi_idx++) begin : g_leg
      dtg_leg #(
        .DT_W   (DT_W),
        .DT_RST (DT_RST)
      ) u_leg (
        .clk    (clk),
        .rst    (rst),
        .i_gi   (bus.gi[gi_idx]),
        .i_rise (r_rise),
        .i_fall (r_fall),
        .i_hold (w_hold),
        .o_go_h (w_go_h[gi_idx]),
        .o_go_l (w_go_l[gi_idx]),
        .o_busy (w_busy[gi_idx])
      );
    end
  endgenerate

  assign bus.go_h = w_go_h;
  assign bus.go_l = w_go_l;
  assign bus.busy = w_busy;

endmodule : dead_band_bridge

`default_nettype wire

// File: tb/tb_dead_band_bridge.sv
// ============================================================================
// Module      : tb_dead_band_bridge
// Description : Self-checking bench for dead_band_bridge against a per-leg
//               "target side + remaining dead cycles" reference model.
//               Fault scenario runs only when DTG_FAULT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dead_band_bridge;

  localparam int c_N_LEG  = 3;
  localparam int c_DT_W   = 8;
  localparam int c_DT_RST = 15;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  // Model state: side each leg is heading to, dead cycles still to go.
  int   m_tgt  [c_N_LEG];
  int   m_rem  [c_N_LEG];
  int   m_rise;
  int   m_fall;
  logic m_held;
  logic m_fq;

  dead_band_bridge_if #(.N_LEG(c_N_LEG), .DT_W(c_DT_W)) bus ();

  dead_band_bridge #(
    .N_LEG  (c_N_LEG),
    .DT_W   (c_DT_W),
    .DT_RST (c_DT_RST)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic hold;
    logic f_in;
    logic c_in;
    f_in = 1'b0;
    c_in = 1'b0;
`ifdef DTG_FAULT_EN
    f_in = bus.fault;
    c_in = bus.fault_clr;
`endif
    if (rst) begin
      for (int i = 0; i < c_N_LEG; i++) begin
        m_tgt[i] = 0;
        m_rem[i] = c_DT_RST;
      end
      m_rise = c_DT_RST;
      m_fall = c_DT_RST;
      m_fq   = 1'b0;
      m_held = 1'b0;
    end else begin
      hold = f_in | m_fq;
      for (int i = 0; i < c_N_LEG; i++) begin
        int g;
        g = int'(bus.gi[i]);
        if (hold) begin
          m_tgt[i] = 0;
          m_rem[i] = m_fall;
        end else if (g != m_tgt[i]) begin
          // Reversal mid-dead aborts straight back; otherwise start a new dead.
          m_rem[i] = (m_rem[i] != 0) ? 0 : ((g == 1) ? m_rise : m_fall);
          m_tgt[i] = g;
        end else if (m_rem[i] != 0) begin
          m_rem[i] = m_rem[i] - 1;
        end
      end
      m_held = hold;
      if (f_in)      m_fq = 1'b1;
      else if (c_in) m_fq = 1'b0;
      if (bus.dt_load) begin
        m_rise = int'(bus.dt_rise);
        m_fall = int'(bus.dt_fall);
      end
    end
  endtask

  task automatic step();
    logic [c_N_LEG-1:0] e_h;
    logic [c_N_LEG-1:0] e_l;
    logic [c_N_LEG-1:0] e_b;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < c_N_LEG; i++) begin
      e_h[i] = !m_held && (m_tgt[i] == 1) && (m_rem[i] == 0);
      e_l[i] = !m_held && (m_tgt[i] == 0) && (m_rem[i] == 0);
      e_b[i] = m_held || (m_rem[i] != 0);
    end
    chk("go_h", 32'(bus.go_h), 32'(e_h));
    chk("go_l", 32'(bus.go_l), 32'(e_l));
    chk("busy", 32'(bus.busy), 32'(e_b));
    chk("overlap", 32'(bus.go_h & bus.go_l), 32'd0);
`ifdef DTG_FAULT_EN
    chk("fault_q", 32'(bus.fault_q), 32'(m_fq));
`endif
  endtask

  task automatic load_dt(input int rise, input int fall);
    bus.dt_rise = c_DT_W'(rise);
    bus.dt_fall = c_DT_W'(fall);
    bus.dt_load = 1'b1;
    step();
    bus.dt_load = 1'b0;
  endtask

  task automatic count_busy(input int leg, output int n);
    n = 0;
    while (bus.busy[leg] && n < 300) begin
      n++;
      step();
    end
  endtask

  int n_dead;

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    bus.gi      = '0;
    bus.dt_rise = '0;
    bus.dt_fall = '0;
    bus.dt_load = 1'b0;
`ifdef DTG_FAULT_EN
    bus.fault     = 1'b0;
    bus.fault_clr = 1'b0;
`endif

    // 1: reset exit walks the DT_RST low-side dead interval
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'h7);
    rst = 1'b0;
    count_busy(0, n_dead);
    chk("t1_dead_l", 32'(n_dead), 32'd15);
    chk("t1_low_on", 32'(bus.go_l), 32'h7);

    // 2: rise=4 / fall=6 with 40-cycle half periods
    load_dt(4, 6);
    for (int p = 0; p < 2; p++) begin
      bus.gi = '1;
      step();
      count_busy(0, n_dead);
      chk("t2_dead_h", 32'(n_dead), 32'd4);
      repeat (35) step();
      bus.gi = '0;
      step();
      count_busy(0, n_dead);
      chk("t2_dead_l", 32'(n_dead), 32'd6);
      repeat (33) step();
    end

    // 3: zero rise dead time switches on the sampling edge
    load_dt(0, 3);
    bus.gi = 3'b001;
    step();
    chk("t3_go_h", 32'(bus.go_h[0]), 32'd1);
    chk("t3_go_l", 32'(bus.go_l[0]), 32'd0);
    bus.gi = '0;
    repeat (6) step();

    // 4: gi pulse shorter than the dead time aborts
    load_dt(10, 3);
    bus.gi = 3'b001;
    repeat (3) step();
    bus.gi = '0;
    step();
    chk("t4_abort_l", 32'(bus.go_l[0]), 32'd1);
    chk("t4_abort_h", 32'(bus.go_h[0]), 32'd0);
    repeat (4) step();

    // 5: reload during leg0's dead interval keeps captured limit
    bus.gi = 3'b001;
    step();
    load_dt(2, 3);
    step();
    count_busy(0, n_dead);
    chk("t5_kept", 32'(n_dead), 32'd8);
    bus.gi = 3'b000;
    repeat (6) step();
    bus.gi = 3'b011;
    step();
    count_busy(0, n_dead);
    chk("t5_new", 32'(n_dead), 32'd2);
    bus.gi = '0;
    repeat (6) step();

    // Random gi toggling with occasional dead-time reloads
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < c_N_LEG; i++)
        if ($urandom_range(0, 11) == 0) bus.gi[i] = ~bus.gi[i];
      if ($urandom_range(0, 19) == 0) begin
        bus.dt_rise = c_DT_W'($urandom_range(0, 7));
        bus.dt_fall = c_DT_W'($urandom_range(0, 7));
        bus.dt_load = 1'b1;
      end
      step();
      bus.dt_load = 1'b0;
    end

`ifdef DTG_FAULT_EN
    // 6: fault forces all gates off, clear resumes through DEAD_L
    load_dt(2, 5);
    bus.gi = '1;
    repeat (10) step();
    bus.fault = 1'b1;
    step();
    bus.fault = 1'b0;
    chk("t6_off_h", 32'(bus.go_h), 32'd0);
    chk("t6_off_l", 32'(bus.go_l), 32'd0);
    bus.gi = '0;
    repeat (4) step();
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    count_busy(0, n_dead);
    chk("t6_resume", 32'(n_dead), 32'd5);
    repeat (4) step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dead_band_bridge

`default_nettype wire
